// File: rtl/ann_pkg.sv
// Shared types and sizing helpers for the ANN neuron fabric.
package ann_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } neuron_state_t;

    // Smallest k with 2**k >= n.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = int'(i) + 1;
        end
        return r;
    endfunction

    function automatic int acc_w(input int weight_w, input int connections);
        return weight_w + clog2(connections + 1) + 1;
    endfunction

    localparam int ACC_W_DEFAULT = acc_w(4, 8);

endpackage

// File: rtl/neuron_weight_rf.sv
// Per-neuron weight register file: one write port, LANES combinational read ports.
module neuron_weight_rf
    import ann_pkg::*;
#(
    parameter int CONNECTIONS = 8,
    parameter int LANES       = 2,
    parameter int WEIGHT_W    = 4,
    parameter int ADDR_W      = 3,
    parameter int IDX_W       = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [WEIGHT_W-1:0]       wdata_i,
    input  logic [LANES*IDX_W-1:0]    rd_idx_i,
    output logic [LANES*WEIGHT_W-1:0] rd_data_o
);

    logic [WEIGHT_W-1:0] w_q [CONNECTIONS];

    // Addresses outside the array never match, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CONNECTIONS; i++) begin
                w_q[i] <= WEIGHT_W'(1);
            end
        end else if (we_i) begin
            for (int unsigned i = 0; i < CONNECTIONS; i++) begin
                if (waddr_i == ADDR_W'(i)) w_q[i] <= wdata_i;
            end
        end
    end

    // Lane indices past the last connection read as zero weight.
    always_comb begin
        rd_data_o = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned i = 0; i < CONNECTIONS; i++) begin
                if (rd_idx_i[l*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    rd_data_o[l*WEIGHT_W +: WEIGHT_W] = w_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/seq_threshold_neuron.sv
// Clocked weighted threshold neuron: serial LANES-wide accumulation, valid/ready in and out.
module seq_threshold_neuron
    import ann_pkg::*;
#(
    parameter int CONNECTIONS = 8,
    parameter int LANES       = 2,
    parameter int WEIGHT_W    = 4,
    parameter int THR_RESET   = CONNECTIONS / 2,
    parameter int INVERT      = 1,
    localparam int ACC_W      = acc_w(WEIGHT_W, CONNECTIONS),
    localparam int ADDR_W     = (clog2(CONNECTIONS) < 1) ? 1 : clog2(CONNECTIONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_we,
    input  logic [ADDR_W-1:0]      w_addr,
    input  logic [WEIGHT_W-1:0]    w_data,
    input  logic                   thr_we,
    input  logic [ACC_W-1:0]       thr_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   enable,
    input  logic [CONNECTIONS-1:0] in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   fire,
    output logic [ACC_W-1:0]       sum,
    output logic                   busy
);

    localparam int IDX_W    = clog2(CONNECTIONS + LANES) + 1;
    localparam int NSTEPS   = (CONNECTIONS + LANES - 1) / LANES;
    localparam int LAST_IDX = (NSTEPS - 1) * LANES;

    neuron_state_t state_q, state_d;

    logic [IDX_W-1:0]       idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic signed [ACC_W-1:0] thr_q, thr_d;
    logic [CONNECTIONS-1:0] vec_q, vec_d;
    logic                   en_q, en_d;
    logic                   fire_q, fire_d;

    logic                      rf_we;
    logic [LANES*IDX_W-1:0]    rd_idx;
    logic [LANES*WEIGHT_W-1:0] rd_data;
    logic signed [ACC_W-1:0]   lane_sum;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      raw;

    neuron_weight_rf #(
        .CONNECTIONS (CONNECTIONS),
        .LANES       (LANES),
        .WEIGHT_W    (WEIGHT_W),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_weight_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (w_addr),
        .wdata_i   (w_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    always_comb begin
        rd_idx   = '0;
        lane_sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            rd_idx[l*IDX_W +: IDX_W] = idx_q + IDX_W'(l);
            for (int unsigned i = 0; i < CONNECTIONS; i++) begin
                if (rd_idx[l*IDX_W +: IDX_W] == IDX_W'(i) && vec_q[i]) begin
                    lane_sum = lane_sum + ACC_W'($signed(rd_data[l*WEIGHT_W +: WEIGHT_W]));
                end
            end
        end
        acc_next = acc_q + lane_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Config writes are only opened in IDLE; the RF write lands on the acceptance
    // edge, so a same-cycle write is already visible to the first ACCUM read.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        vec_d   = vec_q;
        en_d    = en_q;
        sum_d   = sum_q;
        fire_d  = fire_q;
        thr_d   = thr_q;
        rf_we   = 1'b0;
        raw     = 1'b0;
        case (state_q)
            IDLE: begin
                rf_we = w_we;
                if (thr_we) thr_d = thr_data;
                if (in_valid) begin
                    vec_d   = in_vec;
                    en_d    = enable;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                idx_d = idx_q + IDX_W'(LANES);
                if (idx_q == IDX_W'(LAST_IDX)) begin
                    raw     = (acc_next >= thr_q);
                    sum_d   = acc_next;
                    fire_d  = en_q & ((INVERT != 0) ? ~raw : raw);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            acc_q  <= '0;
            vec_q  <= '0;
            en_q   <= 1'b0;
            sum_q  <= '0;
            fire_q <= 1'b0;
            thr_q  <= ACC_W'(THR_RESET);
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            vec_q  <= vec_d;
            en_q   <= en_d;
            sum_q  <= sum_d;
            fire_q <= fire_d;
            thr_q  <= thr_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign fire      = fire_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_seq_threshold_neuron.sv
// Randomised bench for seq_threshold_neuron: two builds (LANES=2/INVERT=1, LANES=3/INVERT=0) vs a sum-of-weights model.
module tb_seq_threshold_neuron;
    import ann_pkg::*;

    localparam int C  = 8;
    localparam int AW = acc_w(4, C);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_we = 1'b0;
    logic [2:0]    w_addr = '0;
    logic [3:0]    w_data = '0;
    logic          thr_we = 1'b0;
    logic [AW-1:0] thr_data = '0;
    logic          in_valid = 1'b0;
    logic          enable = 1'b0;
    logic [C-1:0]  in_vec = '0;
    logic          out_ready = 1'b0;

    logic          a_in_ready, a_out_valid, a_fire, a_busy;
    logic [AW-1:0] a_sum;
    logic          b_in_ready, b_out_valid, b_fire, b_busy;
    logic [AW-1:0] b_sum;

    int checks = 0;
    int errors = 0;
    int wm [C];
    int thr_m;

    always #5 clk = ~clk;

    seq_threshold_neuron #(
        .CONNECTIONS (8), .LANES (2), .WEIGHT_W (4), .THR_RESET (4), .INVERT (1)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .w_we (w_we), .w_addr (w_addr), .w_data (w_data),
        .thr_we (thr_we), .thr_data (thr_data), .in_valid (in_valid), .in_ready (a_in_ready),
        .enable (enable), .in_vec (in_vec), .out_valid (a_out_valid), .out_ready (out_ready),
        .fire (a_fire), .sum (a_sum), .busy (a_busy)
    );

    seq_threshold_neuron #(
        .CONNECTIONS (8), .LANES (3), .WEIGHT_W (4), .THR_RESET (4), .INVERT (0)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .w_we (w_we), .w_addr (w_addr), .w_data (w_data),
        .thr_we (thr_we), .thr_data (thr_data), .in_valid (in_valid), .in_ready (b_in_ready),
        .enable (enable), .in_vec (in_vec), .out_valid (b_out_valid), .out_ready (out_ready),
        .fire (b_fire), .sum (b_sum), .busy (b_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_sum(input logic [C-1:0] v);
        int s = 0;
        for (int i = 0; i < C; i++) if (v[i]) s += wm[i];
        return s;
    endfunction

    function automatic int ref_fire(input int s, input bit en, input bit inv);
        if (!en) return 0;
        return inv ? int'(s < thr_m) : int'(s >= thr_m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < C; i++) wm[i] = 1;
        thr_m = 4;
    endtask

    task automatic write_w(input int addr, input int val);
        @(negedge clk);
        w_we = 1'b1; w_addr = addr[2:0]; w_data = val[3:0];
        @(negedge clk);
        w_we = 1'b0;
        wm[addr] = val;
    endtask

    task automatic write_thr(input int t);
        @(negedge clk);
        thr_we = 1'b1; thr_data = AW'(t);
        @(negedge clk);
        thr_we = 1'b0;
        thr_m = t;
    endtask

    task automatic run_vec(input logic [C-1:0] v, input bit en, input int hold,
                           input bit busy_wr, input bit same_wr, input int wa, input int wv);
        int s, fa, fb, lat_a, lat_b;
        @(negedge clk);
        check("in_ready_a_idle", int'(a_in_ready), 1);
        check("in_ready_b_idle", int'(b_in_ready), 1);
        in_vec = v; enable = en; in_valid = 1'b1;
        if (same_wr) begin
            w_we = 1'b1; w_addr = wa[2:0]; w_data = wv[3:0];
            wm[wa] = wv;
        end
        s  = ref_sum(v);
        fa = ref_fire(s, en, 1'b1);
        fb = ref_fire(s, en, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; w_we = 1'b0;
        in_vec = C'($urandom); enable = ~en;
        check("busy_a_accum", int'(a_busy), 1);
        check("in_ready_a_accum", int'(a_in_ready), 0);
        lat_a = 0; lat_b = 0;
        for (int k = 1; k <= 12 && (lat_a == 0 || lat_b == 0); k++) begin
            if (busy_wr && k == 1) begin
                w_we = 1'b1; w_addr = wa[2:0]; w_data = wv[3:0];
                thr_we = 1'b1; thr_data = AW'($urandom_range(40));
            end
            @(negedge clk);
            w_we = 1'b0; thr_we = 1'b0;
            if (a_out_valid && lat_a == 0) lat_a = k;
            if (b_out_valid && lat_b == 0) lat_b = k;
        end
        check("latency_a", lat_a, 4);
        check("latency_b", lat_b, 3);
        check("sum_a", int'($signed(a_sum)), s);
        check("sum_b", int'($signed(b_sum)), s);
        check("fire_a", int'(a_fire), fa);
        check("fire_b", int'(b_fire), fb);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid_a", int'(a_out_valid), 1);
            check("hold_valid_b", int'(b_out_valid), 1);
            check("hold_sum_a", int'($signed(a_sum)), s);
            check("hold_fire_a", int'(a_fire), fa);
            check("hold_fire_b", int'(b_fire), fb);
            check("hold_in_ready_a", int'(a_in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid_a", int'(a_out_valid), 0);
        check("post_valid_b", int'(b_out_valid), 0);
        check("post_in_ready_a", int'(a_in_ready), 1);
        check("post_in_ready_b", int'(b_in_ready), 1);
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_in_ready", int'(a_in_ready), 1);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_fire", int'(a_fire), 0);
        check("rst_sum", int'(a_sum), 0);
        check("rst_busy", int'(a_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(8'h0F, 1'b1, 0, 1'b0, 1'b0, 0, 0);
        run_vec(8'h07, 1'b1, 0, 1'b0, 1'b0, 0, 0);

        write_w(0, -8);
        write_w(1, 7);
        write_thr(0);
        run_vec(8'h03, 1'b1, 1, 1'b0, 1'b0, 0, 0);

        run_vec(8'hFF, 1'b0, 5, 1'b0, 1'b0, 0, 0);

        run_vec(8'h04, 1'b1, 0, 1'b1, 1'b0, 2, -1);
        run_vec(8'h04, 1'b1, 0, 1'b0, 1'b1, 2, -1);

        // Abort in the second ACCUM cycle; everything, weights included, reverts.
        @(negedge clk);
        in_vec = 8'hFF; enable = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(a_out_valid), 0);
        check("arst_in_ready", int'(a_in_ready), 1);
        check("arst_busy_b", int'(b_busy), 0);
        check("arst_sum", int'(a_sum), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(8'hFF, 1'b1, 0, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int nw;
            nw = int'($urandom_range(2));
            for (int j = 0; j < nw; j++) write_w(int'($urandom_range(7)), int'($urandom_range(15)) - 8);
            if ($urandom_range(3) == 0) write_thr(int'($urandom_range(40)) - 20);
            run_vec(C'($urandom), ($urandom_range(4) != 0), int'($urandom_range(3)),
                    ($urandom_range(4) == 0), ($urandom_range(4) == 0),
                    int'($urandom_range(7)), int'($urandom_range(15)) - 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
